// File: rtl/decoder_2to4_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_2to4_strobe
//  Description : Sequential binary-to-one-hot decoder. A code accepted over a
//                valid/ready handshake drives the matching output line as a
//                strobe HOLD cycles long. Each strobe is followed by GAP idle
//                cycles. A one-entry pending register lets the sender queue
//                the next code while a strobe or gap is still in progress.
//
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                en         - enable; when low no new codes are accepted
//                code_in    - binary code, code i selects y[i]
//                code_valid - code_in valid this cycle
//                code_ready - a code can be accepted this cycle
//                y          - registered one-hot strobe (or zero)
//                y_valid    - high exactly while y is non-zero
//                busy       - strobe/gap in progress or a code is pending
//
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_2to4_strobe #(
    parameter int CODE_W = 2,
    parameter int HOLD   = 3,
    parameter int GAP    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [CODE_W-1:0]      code_in,
    input  logic                   code_valid,
    output logic                   code_ready,
    output logic [2**CODE_W-1:0]   y,
    output logic                   y_valid,
    output logic                   busy
);

    localparam int          c_OUT_W   = 2**CODE_W;
    localparam logic [7:0]  c_HOLD_M1 = 8'(HOLD - 1);
    localparam logic [7:0]  c_GAP_M1  = 8'(GAP - 1);
    localparam bit          c_HAS_GAP = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [c_OUT_W-1:0]   y_q, y_d;
    logic [CODE_W-1:0]    pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;

    logic                 w_xfer;
    logic                 w_reload;

    function automatic logic [c_OUT_W-1:0] f_onehot(input logic [CODE_W-1:0] code);
        logic [c_OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    // Gating with rst_n keeps ready low while the block is held in reset,
    // even though the pending flag itself is already clear.
    assign code_ready = rst_n & en & ~pend_full_q;
    assign w_xfer     = code_valid & code_ready;
    assign w_reload   = pend_full_q & en;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        case (state_q)
            ST_IDLE: begin
                // A direct transfer and a pending reload are mutually
                // exclusive: ready is low whenever the pending slot is full.
                if (w_xfer) begin
                    y_d     = f_onehot(code_in);
                    cnt_d   = c_HOLD_M1;
                    state_d = ST_DRIVE;
                end else if (w_reload) begin
                    y_d         = f_onehot(pend_q);
                    cnt_d       = c_HOLD_M1;
                    pend_full_d = 1'b0;
                    state_d     = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == 8'd0) begin
                    y_d = '0;
                    if (c_HAS_GAP) begin
                        state_d = ST_GAP;
                        cnt_d   = c_GAP_M1;
                    end else if (w_reload) begin
                        // Without a gap the next strobe replaces the current
                        // one on the same edge; y goes straight from one
                        // one-hot value to another, never through two bits.
                        y_d         = f_onehot(pend_q);
                        cnt_d       = c_HOLD_M1;
                        pend_full_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_GAP: begin
                y_d = '0;
                if (cnt_q == 8'd0) begin
                    if (w_reload) begin
                        y_d         = f_onehot(pend_q);
                        cnt_d       = c_HOLD_M1;
                        pend_full_d = 1'b0;
                        state_d     = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                y_d     = '0;
            end
        endcase

        // Codes arriving while a strobe or gap is running are parked.
        if (w_xfer && (state_q != ST_IDLE)) begin
            pend_d      = code_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            y_q         <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign y       = y_q;
    assign y_valid = |y_q;
    assign busy    = (state_q != ST_IDLE) | pend_full_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_2to4_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_2to4_strobe
//  Description : Self-checking bench for decoder_2to4_strobe. Two instances
//                are exercised: the default build (HOLD=3, GAP=1) and a
//                HOLD=1, GAP=0 build. A timing model predicts, for every
//                accepted code, the edge at which its strobe starts and
//                pushes it into a scoreboard queue; a monitor on the falling
//                edge pops entries and compares y, y_valid, code_ready and
//                busy every cycle.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_2to4_strobe;

    typedef struct {
        int code;
        int start;
    } exp_t;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: actual %0h, required %0h",
                     name, inst, $time, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int H = (gi == 0) ? 3 : 1;
        localparam int G = (gi == 0) ? 1 : 0;

        logic       rst_n;
        logic       en;
        logic [1:0] code_in;
        logic       code_valid;
        logic       code_ready;
        logic [3:0] y;
        logic       y_valid;
        logic       busy;

        decoder_2to4_strobe #(
            .CODE_W (2),
            .HOLD   (H),
            .GAP    (G)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .code_in    (code_in),
            .code_valid (code_valid),
            .code_ready (code_ready),
            .y          (y),
            .y_valid    (y_valid),
            .busy       (busy)
        );

        // ---------------- reference timing model ----------------
        // A strobe starting at edge s is visible for cycles s..s+H-1 and the
        // block next decides what to do at edge s+H+G (m_d). A code accepted
        // at edge a starts at a if the block was idle, otherwise at the first
        // enabled edge not before max(m_d, a+1).
        int   edge_n  = 0;
        int   m_d     = -1;
        bit   m_pend  = 1'b0;
        int   m_pcode = 0;
        int   m_pmin  = 0;
        bit   m_ready = 1'b0;
        exp_t q[$];

        always @(posedge clk) begin
            edge_n++;
            if (!rst_n) begin
                m_pend = 1'b0;
                m_d    = -1;
                q.delete();
            end else begin
                if (m_pend && en && edge_n >= m_pmin) begin
                    q.push_back('{code: m_pcode, start: edge_n});
                    m_d    = edge_n + H + G;
                    m_pend = 1'b0;
                end
                if (code_valid && m_ready) begin
                    if (edge_n > m_d) begin
                        q.push_back('{code: int'(code_in), start: edge_n});
                        m_d = edge_n + H + G;
                    end else begin
                        m_pend  = 1'b1;
                        m_pcode = int'(code_in);
                        m_pmin  = (m_d > edge_n + 1) ? m_d : edge_n + 1;
                    end
                end
            end
        end

        // ---------------- scoreboard monitor ----------------
        int         rem = 0;
        logic [3:0] cur = 4'd0;

        always @(negedge clk) begin
            logic [3:0] exp_y;
            exp_t       e;
            m_ready = rst_n & en & !m_pend;
            if (!rst_n) begin
                rem = 0;
            end else begin
                if (q.size() > 0 && q[0].start < edge_n) begin
                    check("sb_start", gi, edge_n, q[0].start);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].start == edge_n) begin
                    e   = q.pop_front();
                    cur = 4'(1 << e.code);
                    rem = H;
                end
                exp_y = (rem > 0) ? cur : 4'd0;
                check("y", gi, y, exp_y);
                check("y_valid", gi, y_valid, |exp_y);
                check("onehot", gi, ($countones(y) <= 1), 1);
                check("code_ready", gi, code_ready, m_ready);
                check("busy", gi, busy, (edge_n < m_d) || m_pend);
                if (rem > 0) rem--;
            end
        end

        // ---------------- stimulus ----------------
        logic rdy_s = 1'b0;
        logic hs    = 1'b0;

        task automatic step();
            @(negedge clk);
            rdy_s = code_ready;
            @(posedge clk);
            hs = code_valid & rdy_s;
            #1;
        endtask

        task automatic send(input int c);
            code_valid = 1'b1;
            code_in    = 2'(c);
            hs         = 1'b0;
            for (int k = 0; k < 200 && !hs; k++) step();
            check("send_accept", gi, hs, 1);
            code_valid = 1'b0;
        endtask

        task automatic idle(input int n);
            code_valid = 1'b0;
            repeat (n) step();
        endtask

        initial begin
            rst_n      = 1'b0;
            en         = 1'b0;
            code_in    = 2'd0;
            code_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            en = 1'b1;
            @(negedge clk);
            check("rst_y", gi, y, 0);
            check("rst_y_valid", gi, y_valid, 0);
            check("rst_ready", gi, code_ready, 0);
            check("rst_busy", gi, busy, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;

            // single code
            send(2);
            idle(10);

            // back-to-back, third offered while the pending slot is full
            send(3);
            send(0);
            send(1);
            idle(15);

            // enable dropped with a code pending
            send(1);
            send(2);
            en = 1'b0;
            idle(12);
            en = 1'b1;
            idle(12);

            // asynchronous reset during a strobe with a code pending
            send(3);
            send(1);
            #2;
            rst_n = 1'b0;
            #1;
            check("async_y", gi, y, 0);
            check("async_y_valid", gi, y_valid, 0);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            idle(10);

            // continuous codes
            for (int c = 0; c < 4; c++) send(c);
            idle(12);

            // randomized traffic; code held stable while waiting for ready
            for (int i = 0; i < 400; i++) begin
                if (!code_valid || hs) begin
                    code_valid = ($urandom_range(0, 9) < 6);
                    code_in    = 2'($urandom_range(0, 3));
                end
                en = ($urandom_range(0, 9) != 0);
                step();
            end
            en = 1'b1;
            idle(30);
            n_done++;
        end
    end

    initial begin
        for (int k = 0; k < 20000 && n_done < 2; k++) @(posedge clk);
        if (n_done < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL watchdog @%0t: actual %0d instances done, required 2",
                     $time, n_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
